graph_point_gen: RTL and testbench
==================================

Name: graph_point_gen

Overview:
- Parametrised generator that fills an internal table with N_POINTS random (x, y) points for the graph datapath.
- Each coordinate is bounded by rejection sampling to [0, X_MAX] / [0, Y_MAX].
- Generation is started by a start/seed handshake, so a new, reproducible point set can be made without reset.
- Each point is streamed out as it is committed; a combinational read port gives random access to the whole set.

Parameters:
N_POINTS, 64, number of points generated per run (>=2)
COORD_W, 8, coordinate width in bits (1..32)
X_MAX, 255, inclusive upper bound for x (< 2**COORD_W)
Y_MAX, 255, inclusive upper bound for y (< 2**COORD_W)
IDX_W, $clog2(N_POINTS), index width (derived, not overridden)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  start request; sampled only in IDLE or DONE
seed  in  32  PRNG seed, sampled with start; 0 is replaced by DEFAULT_SEED
busy  out  1  high while generating
complete  out  1  high from last commit until next accepted start or rst
pt_valid  out  1  one-cycle pulse per committed point
pt_idx  out  IDX_W  index of committed point
pt_x  out  COORD_W  committed x
pt_y  out  COORD_W  committed y
rd_addr  in  IDX_W  table read address
rd_x  out  COORD_W  combinational table read, x
rd_y  out  COORD_W  combinational table read, y

Behaviour:
- Reset values: busy=0, complete=0, pt_valid=0, pt_idx=0, pt_x=0, pt_y=0, FSM=IDLE, PRNG state=DEFAULT_SEED. Table contents are not cleared.
- PRNG: xorshift32 (<<13, >>17, <<5).
  - rnd = current state register.
  - On an accepted start: state <= step(seed_eff).
  - Otherwise the state advances one step every cycle busy=1 and holds when idle.
- FSM states: IDLE, DRAW_X, DRAW_Y, DONE.
  - In IDLE or DONE, start=1: idx<=0, complete<=0, busy<=1, go to DRAW_X.
  - While busy, start is ignored.
  - DRAW_X: cand = rnd[COORD_W-1:0]. If cand <= X_MAX, latch x and go to DRAW_Y; else stay (redraw next cycle).
  - DRAW_Y: same rule against Y_MAX.
  - On acceptance in DRAW_Y: table[idx] <= (x, y); pt_valid, pt_idx, pt_x, pt_y are registered on that same edge.
  - If idx == N_POINTS-1 after a commit: busy<=0, complete<=1, go to DONE. Otherwise idx++ and go to DRAW_X.
- Timing with no rejections:
  - First pt_valid is high in the 3rd cycle after the start edge.
  - Points are committed every 2 cycles.
  - complete rises on the same edge as the last pt_valid.
- pt_x, pt_y and pt_idx hold their last values between pulses.
- Bounds: X_MAX = 2**COORD_W-1 never rejects. Worst-case rejection is unbounded in theory; no timeout.
- Read port: reflects the table at all times, including mid-run (partially overwritten) and after a reset mid-run (stale data).
- Reset mid-run: returns to IDLE immediately. No pt_valid follows.

Optional Feature:
- Macro GRAPH_POINT_GEN_DEDUP_EN.
- Defined: adds state CHECK after DRAW_Y acceptance.
  - CHECK scans table[0..idx-1], one entry per cycle.
  - Any exact (x, y) match discards the candidate and returns to DRAW_X.
  - No match commits the point. idx=0 commits immediately.
  - All committed points are then distinct. Requires (X_MAX+1)*(Y_MAX+1) >= N_POINTS, checked by an elaboration-time assertion.
- Undefined: no CHECK state; duplicates are allowed.

Decomposition:
- Package graph_pkg:
  - state enum (IDLE, DRAW_X, DRAW_Y, CHECK, DONE)
  - DEFAULT_SEED = 32'h92D68CA2
  - xorshift shift constants 13/17/5
- One sub-module, xorshift32_seeded: ports clk, rst, load, seed, en, res. Loads step(seed) on load, steps on en.

Test Plan:
- rst, then start with seed=1, defaults -> cycle 3: pt_valid=1, pt_idx=0, pt_x=0x21, pt_y=0x01; 64 pulses; complete=1 on edge 129 after start; busy=0.
- Seed=1, X_MAX=31 -> 0x21 rejected; pt_x of point 0 = 0x01; every pt_x <= 31 and pt_y <= Y_MAX over all points.
- Two runs with seed=0 and with seed=32'h92D68CA2 -> identical pt stream; after complete, sweep rd_addr 0..63 -> matches the streamed values.
- start pulsed while busy -> ignored, sequence unchanged; start in DONE -> complete drops next cycle and a new run begins.
- rst asserted after 10 pt_valid pulses -> next cycle busy=0, complete=0, no further pt_valid; rd_addr=5 still returns point 5.
- DEDUP_EN with X_MAX=Y_MAX=7, N_POINTS=64 -> completes with all 64 points distinct (full 8x8 grid covered).

Source files
------------

// File: rtl/graph_point_gen_pkg.sv
// Shared definitions for the graph point generator: FSM state encoding,
// PRNG default seed, and the xorshift32 step function.
package graph_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW_X,
        DRAW_Y,
        CHECK,
        DONE
    } state_t;

    localparam logic [31:0] DEFAULT_SEED = 32'h92D6_8CA2;

    localparam int XS_SHIFT_A = 13;
    localparam int XS_SHIFT_B = 17;
    localparam int XS_SHIFT_C = 5;

    // One xorshift32 iteration: left 13, right 17, left 5.
    function automatic logic [31:0] xorshift_step(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << XS_SHIFT_A);
        t = t ^ (t >> XS_SHIFT_B);
        t = t ^ (t << XS_SHIFT_C);
        return t;
    endfunction

endpackage

// File: rtl/graph_point_gen_xorshift32_seeded.sv
// xorshift32 PRNG with a seed-load port. The register itself is the random
// value; load places step(seed) in it, en advances it by one step.
module xorshift32_seeded
    import graph_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        en,
    output logic [31:0] res
);

    // PRNG state register: reset to the default seed, load wins over step.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= DEFAULT_SEED;
        end else if (load) begin
            res <= xorshift_step(seed);
        end else if (en) begin
            res <= xorshift_step(res);
        end
    end

endmodule

// File: rtl/graph_point_gen.sv
// Random (x, y) point table generator. A start/seed handshake launches a run
// that draws bounded coordinates by rejection sampling, commits N_POINTS
// points into an internal table and streams each one as it is committed.
// Optional macro GRAPH_POINT_GEN_DEDUP_EN adds a CHECK state that rejects any
// candidate equal to an already committed point.
module graph_point_gen
    import graph_pkg::*;
#(
    parameter int          N_POINTS = 64,
    parameter int          COORD_W  = 8,
    parameter int unsigned X_MAX    = 255,
    parameter int unsigned Y_MAX    = 255,
    parameter int          IDX_W    = $clog2(N_POINTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        seed,
    output logic               busy,
    output logic               complete,
    output logic               pt_valid,
    output logic [IDX_W-1:0]   pt_idx,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y
);

    localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(Y_MAX);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_POINTS - 1);
    localparam longint             FULL_MAX = (64'sd1 <<< COORD_W) - 1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cand;
    logic [COORD_W-1:0] commit_y;
    logic [31:0]        rnd;
    logic [31:0]        seed_eff;
    logic               accept;
    logic               commit;
    logic               x_ok;
    logic               y_ok;

    logic [COORD_W-1:0] tab_x [N_POINTS];
    logic [COORD_W-1:0] tab_y [N_POINTS];

`ifdef GRAPH_POINT_GEN_DEDUP_EN
    logic [COORD_W-1:0] cur_y;
    logic [IDX_W-1:0]   scan;
    logic               hit;

    // A distinct point set must fit inside the coordinate grid.
    if ((longint'(X_MAX) < longint'(N_POINTS)) && (longint'(Y_MAX) < longint'(N_POINTS)) &&
        ((longint'(X_MAX) + 1) * (longint'(Y_MAX) + 1) < longint'(N_POINTS))) begin : g_grid_too_small
        $error("graph_point_gen: coordinate grid smaller than N_POINTS with dedup enabled");
    end

    assign hit = (tab_x[scan] == cur_x) && (tab_y[scan] == cur_y);
`endif

    assign seed_eff = (seed == 32'd0) ? DEFAULT_SEED : seed;
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign cand     = rnd[COORD_W-1:0];

    // Only the low COORD_W bits of the PRNG feed the coordinates.
    if (COORD_W < 32) begin : g_rnd_hi
        logic unused_rnd_hi;
        assign unused_rnd_hi = ^rnd[31:COORD_W];
    end

    // A bound equal to the full coordinate range never rejects.
    if (longint'(X_MAX) == FULL_MAX) begin : g_x_full
        assign x_ok = 1'b1;
    end else begin : g_x_lim
        assign x_ok = (cand <= X_LIM);
    end

    if (longint'(Y_MAX) == FULL_MAX) begin : g_y_full
        assign y_ok = 1'b1;
    end else begin : g_y_lim
        assign y_ok = (cand <= Y_LIM);
    end

    xorshift32_seeded u_prng (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (seed_eff),
        .en   (busy),
        .res  (rnd)
    );

    // Decide whether this cycle commits a point, and with which y.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        commit   = 1'b0;
        commit_y = cand;
        case (state)
            DRAW_Y: begin
`ifdef GRAPH_POINT_GEN_DEDUP_EN
                commit = y_ok && (idx == '0);
`else
                commit = y_ok;
`endif
            end
`ifdef GRAPH_POINT_GEN_DEDUP_EN
            CHECK: begin
                if (!hit && (scan == idx - 1'b1)) begin
                    commit   = 1'b1;
                    commit_y = cur_y;
                end
            end
`endif
            default: ;
        endcase
    end

    // Main FSM with registered status and point-stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            complete <= 1'b0;
            pt_valid <= 1'b0;
            pt_idx   <= '0;
            pt_x     <= '0;
            pt_y     <= '0;
            idx      <= '0;
        end else begin
            pt_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx      <= '0;
                        complete <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DRAW_X;
                    end
                end
                DRAW_X: begin
                    if (x_ok) begin
                        cur_x <= cand;
                        state <= DRAW_Y;
                    end
                end
                DRAW_Y: begin
`ifdef GRAPH_POINT_GEN_DEDUP_EN
                    if (y_ok && !commit) begin
                        cur_y <= cand;
                        scan  <= '0;
                        state <= CHECK;
                    end
`endif
                end
`ifdef GRAPH_POINT_GEN_DEDUP_EN
                CHECK: begin
                    if (hit) begin
                        state <= DRAW_X;
                    end else if (!commit) begin
                        scan <= scan + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase

            if (commit) begin
                pt_valid <= 1'b1;
                pt_idx   <= idx;
                pt_x     <= cur_x;
                pt_y     <= commit_y;
                if (idx == LAST_IDX) begin
                    busy     <= 1'b0;
                    complete <= 1'b1;
                    state    <= DONE;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= DRAW_X;
                end
            end
        end
    end

    // Point table write port; the table keeps its contents across reset.
    // NOTE: the table is deliberately not reset so it maps onto plain RAM;
    // a reset edge only suppresses the write, it never clears entries.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            tab_x[idx] <= cur_x;
            tab_y[idx] <= commit_y;
        end
    end

    assign rd_x = tab_x[rd_addr];
    assign rd_y = tab_y[rd_addr];

endmodule

// File: tb/tb_graph_point_gen.sv
// Self-checking bench for graph_point_gen. A reference model derives the
// expected point list and commit cycle of every point directly from the
// draw/reject rules; a negedge compare process checks the stream each cycle.
module tb_graph_point_gen;

    localparam int NP  = 64;
    localparam int LIM = 30000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [31:0] seed;
    logic        busy, complete, pt_valid;
    logic [5:0]  pt_idx, rd_addr;
    logic [7:0]  pt_x, pt_y, rd_x, rd_y;

    logic        l_start;
    logic [31:0] l_seed;
    logic        l_busy, l_complete, l_pt_valid;
    logic [5:0]  l_pt_idx, l_rd_addr;
    logic [7:0]  l_pt_x, l_pt_y, l_rd_x, l_rd_y;

    graph_point_gen u_dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .busy(busy), .complete(complete), .pt_valid(pt_valid),
        .pt_idx(pt_idx), .pt_x(pt_x), .pt_y(pt_y),
        .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y)
    );

    graph_point_gen #(.X_MAX(31)) u_lim (
        .clk(clk), .rst(rst), .start(l_start), .seed(l_seed),
        .busy(l_busy), .complete(l_complete), .pt_valid(l_pt_valid),
        .pt_idx(l_pt_idx), .pt_x(l_pt_x), .pt_y(l_pt_y),
        .rd_addr(l_rd_addr), .rd_x(l_rd_x), .rd_y(l_rd_y)
    );

`ifdef GRAPH_POINT_GEN_DEDUP_EN
    logic        d_start;
    logic [31:0] d_seed;
    logic        d_busy, d_complete, d_pt_valid;
    logic [5:0]  d_pt_idx, d_rd_addr;
    logic [7:0]  d_pt_x, d_pt_y, d_rd_x, d_rd_y;

    graph_point_gen #(.X_MAX(7), .Y_MAX(7)) u_dd (
        .clk(clk), .rst(rst), .start(d_start), .seed(d_seed),
        .busy(d_busy), .complete(d_complete), .pt_valid(d_pt_valid),
        .pt_idx(d_pt_idx), .pt_x(d_pt_x), .pt_y(d_pt_y),
        .rd_addr(d_rd_addr), .rd_x(d_rd_x), .rd_y(d_rd_y)
    );
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mdl_x [NP];
    logic [7:0] mdl_y [NP];
    int         mdl_edge [NP];

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] s;
        s = v;
        s = s ^ (s << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        return s;
    endfunction

    // Every cycle after the start edge consumes one random word. A point's
    // commit edge (counted from the start edge as 0) is the number of words
    // consumed when it is committed.
    task automatic build_model(input logic [31:0] sd, input int xmax, input int ymax);
        logic [31:0] s;
        logic [7:0]  x, y;
        int          n, k;
        bit          dup;
        s = (sd == 32'd0) ? 32'h92D6_8CA2 : sd;
        n = 0;
        k = 0;
        while (k < NP) begin
            do begin s = xs(s); n++; end while (int'(s[7:0]) > xmax);
            x = s[7:0];
            do begin s = xs(s); n++; end while (int'(s[7:0]) > ymax);
            y = s[7:0];
            dup = 1'b0;
`ifdef GRAPH_POINT_GEN_DEDUP_EN
            for (int j = 0; j < k; j++) begin
                s = xs(s);
                n++;
                if (mdl_x[j] == x && mdl_y[j] == y) begin
                    dup = 1'b1;
                    break;
                end
            end
`endif
            if (!dup) begin
                mdl_x[k]    = x;
                mdl_y[k]    = y;
                mdl_edge[k] = n;
                k++;
            end
        end
    endtask

    // ---------------- cycle-by-cycle compare ----------------
    int cyc        = 0;
    int start_cyc  = 0;
    int run_gen    = 0;
    bit run_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    int         ptr      = 0;
    int         seen_gen = 0;
    int         c_off;
    bit         c_ev;
    logic [7:0] cap_x [NP];
    logic [7:0] cap_y [NP];

    always @(negedge clk) begin
        if (run_gen != seen_gen) begin
            seen_gen = run_gen;
            ptr      = 0;
        end
        if (run_active) begin
            c_off = cyc - start_cyc;
            if (c_off >= 0) begin
                c_ev = (ptr < NP) ? (mdl_edge[ptr] == c_off) : 1'b0;
                check("pt_valid", pt_valid, c_ev);
                if (c_ev) begin
                    check("pt_idx", pt_idx, ptr);
                    check("pt_x", pt_x, mdl_x[ptr]);
                    check("pt_y", pt_y, mdl_y[ptr]);
                    cap_x[ptr] = pt_x;
                    cap_y[ptr] = pt_y;
                    ptr++;
                end else if (ptr > 0) begin
                    check("pt_hold", {pt_idx, pt_x, pt_y}, {6'(ptr - 1), mdl_x[ptr-1], mdl_y[ptr-1]});
                end
                check("complete", complete, ptr == NP);
                check("busy", busy, ptr != NP);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the start edge.
    task automatic do_start(input logic [31:0] s);
        build_model(s, 255, 255);
        start      = 1'b1;
        seed       = s;
        start_cyc  = cyc + 1;
        run_gen    = run_gen + 1;
        run_active = 1'b1;
        tick();
        start = 1'b0;
        seed  = 32'h5A5A_0000;
    endtask

    task automatic wait_complete(output int off);
        int i;
        i = 0;
        while (!complete && i < LIM) begin
            tick();
            i++;
        end
        check("run_complete_seen", complete, 1'b1);
        off = cyc - start_cyc;
    endtask

    logic [7:0] sav_x [NP];
    logic [7:0] sav_y [NP];

    initial begin
        int off, n, i;
        rst = 1'b1; start = 1'b0; seed = '0; rd_addr = '0;
        l_start = 1'b0; l_seed = '0; l_rd_addr = '0;
`ifdef GRAPH_POINT_GEN_DEDUP_EN
        d_start = 1'b0; d_seed = '0; d_rd_addr = '0;
`endif
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst_busy", busy, 1'b0);
        check("rst_complete", complete, 1'b0);
        check("rst_pt_valid", pt_valid, 1'b0);
        check("rst_pt_idx", pt_idx, 6'd0);
        check("rst_pt_x", pt_x, 8'd0);
        check("rst_pt_y", pt_y, 8'd0);
        rst = 1'b0;
        tick();

        // Run 1: seed 1. step(1)=0x00042021, step again=0x04080601.
        do_start(32'd1);
        i = 0;
        while (!pt_valid && i < LIM) begin tick(); i++; end
        check("first_pulse_offset", cyc - start_cyc, 2);
        check("first_pt_idx", pt_idx, 6'd0);
        check("first_pt_x", pt_x, 8'h21);
        check("first_pt_y", pt_y, 8'h01);
        // start while busy must be ignored (compare process keeps the model).
        repeat (15) tick();
        start = 1'b1; seed = 32'h1234_5678;
        tick();
        start = 1'b0;
        wait_complete(off);
`ifndef GRAPH_POINT_GEN_DEDUP_EN
        // Start edge is edge 1, so the 64th commit lands on edge 129.
        check("complete_edge", off, 128);
`endif
        check("busy_after_done", busy, 1'b0);
        tick();

        // Run 2 from DONE with seed 0, then run 3 with the default seed.
        do_start(32'd0);
        wait_complete(off);
        tick();
        for (int k = 0; k < NP; k++) begin
            sav_x[k] = cap_x[k];
            sav_y[k] = cap_y[k];
        end
        do_start(32'h92D6_8CA2);
        wait_complete(off);
        tick();
        for (int k = 0; k < NP; k++)
            check("seed0_vs_default", {cap_x[k], cap_y[k]}, {sav_x[k], sav_y[k]});
        for (int k = 0; k < NP; k++) begin
            rd_addr = 6'(k);
            #2;
            check("rd_sweep", {rd_x, rd_y}, {mdl_x[k], mdl_y[k]});
            tick();
        end

        // Reset after ten committed points.
        do_start(32'hCAFE_F00D);
        n = 0;
        i = 0;
        while (n < 10 && i < LIM) begin
            tick();
            i++;
            if (pt_valid) n++;
        end
        check("ten_pulses_seen", n, 10);
        rst = 1'b1;
        run_active = 1'b0;
        tick();
        check("midrst_busy", busy, 1'b0);
        check("midrst_complete", complete, 1'b0);
        check("midrst_pt_valid", pt_valid, 1'b0);
        check("midrst_pt_idx", pt_idx, 6'd0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("no_pulse_after_rst", pt_valid, 1'b0);
            check("idle_after_rst", busy, 1'b0);
        end
        rd_addr = 6'd5;
        #2;
        check("rd_stale_pt5", {rd_x, rd_y}, {mdl_x[5], mdl_y[5]});
        tick();

        // X_MAX=31 instance, seed 1: 0x21 is rejected, x of point 0 is 0x01.
        build_model(32'd1, 31, 255);
        l_start = 1'b1; l_seed = 32'd1;
        tick();
        l_start = 1'b0;
        n = 0;
        i = 0;
        while (n < NP && i < LIM) begin
            if (l_pt_valid) begin
                if (n == 0) check("lim_first_x", l_pt_x, 8'h01);
                check("lim_idx", l_pt_idx, n);
                check("lim_x", l_pt_x, mdl_x[n]);
                check("lim_y", l_pt_y, mdl_y[n]);
                check("lim_x_bound", l_pt_x <= 8'd31, 1'b1);
                n++;
            end
            if (n < NP) begin tick(); i++; end
        end
        check("lim_count", n, NP);
        check("lim_complete", l_complete, 1'b1);
        tick();

`ifdef GRAPH_POINT_GEN_DEDUP_EN
        // 8x8 grid with 64 points: every cell must be hit exactly once.
        begin
            logic [63:0] grid;
            grid = '0;
            d_start = 1'b1; d_seed = 32'h0BAD_CAFE;
            tick();
            d_start = 1'b0;
            n = 0;
            i = 0;
            while (n < NP && i < 60000) begin
                if (d_pt_valid) begin
                    check("dd_bound", (d_pt_x <= 8'd7) && (d_pt_y <= 8'd7), 1'b1);
                    check("dd_distinct", grid[{d_pt_y[2:0], d_pt_x[2:0]}], 1'b0);
                    grid[{d_pt_y[2:0], d_pt_x[2:0]}] = 1'b1;
                    n++;
                end
                if (n < NP) begin tick(); i++; end
            end
            check("dd_count", n, NP);
            check("dd_grid_full", grid, {64{1'b1}});
            check("dd_complete", d_complete, 1'b1);
            tick();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
